// File: rtl/digit_scan_mux.sv
// ============================================================================
// digit_scan_mux : frame-snapshotted multiplexer of BCD digits onto one bus
//                  with one-hot position strobe, manual select and blanking.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module digit_scan_mux #(
  parameter int                  CHANNELS   = 4,
  parameter int                  DIGIT_W    = 4,
  parameter int                  SCAN_DIV   = 1000,
  parameter int                  SEL_W      = $clog2(CHANNELS),
  parameter logic [DIGIT_W-1:0]  BLANK_CODE = {DIGIT_W{1'b1}}
) (
  input  logic                          clk_scan,
  input  logic                          rst_n_scan,
  input  logic [CHANNELS*DIGIT_W-1:0]   digits_in,
  input  logic                          mode_in,
  input  logic [SEL_W-1:0]              sel_in,
  input  logic                          enable_in,
  input  logic                          lzb_in,
  output logic [DIGIT_W-1:0]            digit_out,
  output logic [CHANNELS-1:0]           sel_out,
  output logic                          frame_out
);

  localparam int PCNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(CHANNELS);
  localparam logic [PCNT_W-1:0] C_PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  C_IDX_LAST  = IDX_W'(CHANNELS - 1);

  logic [PCNT_W-1:0]           pcnt_q,  pcnt_d;
  logic [IDX_W-1:0]            idx_q,   idx_d;
  logic [CHANNELS*DIGIT_W-1:0] snap_q,  snap_d;
  logic [DIGIT_W-1:0]          digit_q, digit_d;
  logic [CHANNELS-1:0]         sel_q,   sel_d;
  logic                        frame_q, frame_d;

  logic                        tick;
  logic                        zero_run;
  logic [CHANNELS-1:0]         lz_blank;

  always_comb begin
    pcnt_d   = pcnt_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    digit_d  = digit_q;
    sel_d    = sel_q;
    frame_d  = 1'b0;
    tick     = (pcnt_q == C_PCNT_LAST);
    zero_run = 1'b1;
    lz_blank = '0;

    // Walk from the most significant digit down; a position is dark while
    // every digit at or above it is zero, but channel 0 always stays lit.
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      zero_run    = zero_run & (snap_q[k*DIGIT_W +: DIGIT_W] == '0);
      lz_blank[k] = lzb_in & zero_run & (k != 0);
    end

    if (!enable_in) begin
      pcnt_d  = '0;
      idx_d   = C_IDX_LAST;
      digit_d = BLANK_CODE;
      sel_d   = '0;
    end else if (mode_in) begin
      pcnt_d = '0;
      idx_d  = C_IDX_LAST;
      // An out-of-range selection matches nothing, so the outputs hold.
      for (int k = 0; k < CHANNELS; k++) begin
        if (sel_in == SEL_W'(k)) begin
          digit_d = digits_in[k*DIGIT_W +: DIGIT_W];
          sel_d   = CHANNELS'(1) << k;
        end
      end
    end else begin
      pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
      if (tick) begin
        idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        if (idx_q == C_IDX_LAST) begin
          snap_d = digits_in;
        end
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (idx_q == IDX_W'(k)) begin
          sel_d   = CHANNELS'(1) << k;
          digit_d = lz_blank[k] ? BLANK_CODE : snap_q[k*DIGIT_W +: DIGIT_W];
        end
      end
      // pcnt is zero with idx at 0 only on the cycle right after the wrap tick.
      frame_d = (idx_q == '0) && (pcnt_q == '0);
    end
  end

  always_ff @(posedge clk_scan or negedge rst_n_scan) begin
    if (!rst_n_scan) begin
      pcnt_q  <= '0;
      idx_q   <= C_IDX_LAST;
      snap_q  <= {CHANNELS{BLANK_CODE}};
      digit_q <= BLANK_CODE;
      sel_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      digit_q <= digit_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
    end
  end

  assign digit_out = digit_q;
  assign sel_out   = sel_q;
  assign frame_out = frame_q;

endmodule

`default_nettype wire
